// File: rtl/mips_pipe_hazard_ctrl.sv
// mips_pipe_hazard_ctrl: stall/flush/forwarding control for a 5-stage MIPS pipeline
module mips_pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_use,
  input  logic              id_rt_use,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              ex_br_taken,
  input  logic              mem_busy,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              wr;
    logic              load;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              rs_use;
    logic              rt_use;
  } slot_t;
  slot_t id_s, ex_s, mem_s, wb_s;
  logic id_ex, id_mem, id_wb, hz, adv, go;
  function automatic logic hit(logic u, logic [REG_AW-1:0] s, slot_t x);
    return u & x.valid & x.wr & (x.dst == s) & (s != '0);
  endfunction
  function automatic logic [1:0] fsel(logic u, logic [REG_AW-1:0] s, slot_t m, slot_t w);
    return hit(u, s, m) ? (m.load ? 2'd0 : 2'd1) : hit(u, s, w) ? 2'd2 : 2'd0;
  endfunction
  assign id_s   = {id_valid, id_dst, id_wr, id_load, id_rs, id_rt, id_rs_use, id_rt_use};
  assign id_ex  = hit(id_rs_use, id_rs, ex_s) | hit(id_rt_use, id_rt, ex_s);
  assign id_mem = hit(id_rs_use, id_rs, mem_s) | hit(id_rt_use, id_rt, mem_s);
  assign id_wb  = hit(id_rs_use, id_rs, wb_s) | hit(id_rt_use, id_rt, wb_s);
  assign hz = id_valid & ((FWD_EN != 0) ? (id_ex & ex_s.load)
                                        : (id_ex | id_mem | ((WB_BYPASS == 0) & id_wb)));
  assign adv = !rst & !mem_busy;
  assign go  = adv & (ex_br_taken | !hz);
  assign pc_en      = go;
  assign ifid_en    = go;
  assign ifid_flush = rst | (adv & ex_br_taken);
  assign idex_flush = rst | (adv & (ex_br_taken | hz));
  assign fwd_a = (rst || FWD_EN == 0) ? 2'd0 : fsel(ex_s.rs_use, ex_s.rs, mem_s, wb_s);
  assign fwd_b = (rst || FWD_EN == 0) ? 2'd0 : fsel(ex_s.rt_use, ex_s.rt, mem_s, wb_s);
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_s      <= '0;
      mem_s     <= '0;
      wb_s      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!mem_busy) begin
      wb_s  <= mem_s;
      mem_s <= ex_s;
      ex_s  <= (ex_br_taken | hz) ? '0 : id_s;
      if (ex_br_taken && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      if (!ex_br_taken && hz && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mips_pipe_hazard_ctrl.sv
// tb_mips_pipe_hazard_ctrl: directed scenarios on three configurations against a pipeline model
module tb_mips_pipe_hazard_ctrl;
  logic clk = 0, rst = 1, id_valid = 0, id_rs_use = 0, id_rt_use = 0, id_wr = 0, id_load = 0;
  logic ex_br_taken = 0, mem_busy = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_dst = 0;
  logic [2:0] pc_en, ifid_en, ifid_flush, idex_flush;
  logic [1:0] fwd_a [3];
  logic [1:0] fwd_b [3];
  logic [15:0] sc0, sc1, fc0, fc1;
  logic [1:0] sc2, fc2;
  logic [15:0] scv [3];
  logic [15:0] fcv [3];
  int errors = 0, checks = 0;
  bit armed = 0;
  always #5 clk = ~clk;
  mips_pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .WB_BYPASS(1), .CNT_W(16)) d0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_use(id_rs_use), .id_rt_use(id_rt_use), .id_dst(id_dst), .id_wr(id_wr),
    .id_load(id_load), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy), .pc_en(pc_en[0]),
    .ifid_en(ifid_en[0]), .ifid_flush(ifid_flush[0]), .idex_flush(idex_flush[0]),
    .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .stall_cnt(sc0), .flush_cnt(fc0));
  mips_pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .WB_BYPASS(1), .CNT_W(16)) d1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_use(id_rs_use), .id_rt_use(id_rt_use), .id_dst(id_dst), .id_wr(id_wr),
    .id_load(id_load), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy), .pc_en(pc_en[1]),
    .ifid_en(ifid_en[1]), .ifid_flush(ifid_flush[1]), .idex_flush(idex_flush[1]),
    .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .stall_cnt(sc1), .flush_cnt(fc1));
  mips_pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .WB_BYPASS(0), .CNT_W(2)) d2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_use(id_rs_use), .id_rt_use(id_rt_use), .id_dst(id_dst), .id_wr(id_wr),
    .id_load(id_load), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy), .pc_en(pc_en[2]),
    .ifid_en(ifid_en[2]), .ifid_flush(ifid_flush[2]), .idex_flush(idex_flush[2]),
    .fwd_a(fwd_a[2]), .fwd_b(fwd_b[2]), .stall_cnt(sc2), .flush_cnt(fc2));
  assign scv[0] = sc0;
  assign scv[1] = sc1;
  assign scv[2] = {14'd0, sc2};
  assign fcv[0] = fc0;
  assign fcv[1] = fc1;
  assign fcv[2] = {14'd0, fc2};
  // Model: in-flight instructions listed by distance ahead of ID (0=EX, 1=MEM, 2=WB)
  typedef struct packed {
    bit v; bit [4:0] d; bit w, l; bit [4:0] rs, rt; bit ru, tu;
  } ent_t;
  ent_t pm [3][3];
  int sc [3], fc [3];
  int cmax [3] = '{65535, 65535, 3};
  bit fe [3] = '{1, 0, 0};
  bit wbb [3] = '{1, 1, 0};
  function automatic bit mt(bit u, bit [4:0] s, ent_t x);
    return u && x.v && x.w && x.d == s && s != 0;
  endfunction
  function automatic logic [1:0] fw(bit u, bit [4:0] s, ent_t m, ent_t w);
    if (mt(u, s, m)) return m.l ? 2'd0 : 2'd1;
    if (mt(u, s, w)) return 2'd2;
    return 2'd0;
  endfunction
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit h, pe, ie, ff, xf;
      logic [1:0] fa, fb;
      logic [39:0] e, g;
      h = 0;
      for (int i = 0; i < 3; i++)
        if ((mt(id_rs_use, id_rs, pm[k][i]) || mt(id_rt_use, id_rt, pm[k][i])) &&
            (fe[k] ? (i == 0 && pm[k][i].l) : (i < 2 || !wbb[k]))) h = 1;
      h = h && id_valid;
      fa = fe[k] ? fw(pm[k][0].ru, pm[k][0].rs, pm[k][1], pm[k][2]) : 2'd0;
      fb = fe[k] ? fw(pm[k][0].tu, pm[k][0].rt, pm[k][1], pm[k][2]) : 2'd0;
      if (rst) begin pe = 0; ie = 0; ff = 1; xf = 1; fa = 0; fb = 0; end
      else if (mem_busy) begin pe = 0; ie = 0; ff = 0; xf = 0; end
      else if (ex_br_taken) begin pe = 1; ie = 1; ff = 1; xf = 1; end
      else if (h) begin pe = 0; ie = 0; ff = 0; xf = 1; end
      else begin pe = 1; ie = 1; ff = 0; xf = 0; end
      e = {pe, ie, ff, xf, fa, fb, 16'(sc[k]), 16'(fc[k])};
      g = {pc_en[k], ifid_en[k], ifid_flush[k], idex_flush[k], fwd_a[k], fwd_b[k], scv[k], fcv[k]};
      if (armed) begin
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL model_dut%0d t=%0t got=%h exp=%h", k, $time, g, e);
        end
      end
      if (rst) begin
        pm[k][0] = '0; pm[k][1] = '0; pm[k][2] = '0; sc[k] = 0; fc[k] = 0;
      end else if (!mem_busy) begin
        pm[k][2] = pm[k][1];
        pm[k][1] = pm[k][0];
        pm[k][0] = (ex_br_taken || h) ? '0 :
                   {id_valid, id_dst, id_wr, id_load, id_rs, id_rt, id_rs_use, id_rt_use};
        if (ex_br_taken) fc[k] = fc[k] < cmax[k] ? fc[k] + 1 : fc[k];
        else if (h) sc[k] = sc[k] < cmax[k] ? sc[k] + 1 : sc[k];
      end
    end
  end
  task automatic step; @(posedge clk); #1; endtask
  task automatic settle; #1; endtask
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask
  task automatic id(input bit v, input int rs, input int rt, input bit ru, input bit tu,
                    input int d, input bit w, input bit l);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_rs_use = ru; id_rt_use = tu;
    id_dst = 5'(d); id_wr = w; id_load = l;
  endtask
  task automatic nop; id(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic alu(input int d, input int rs, input int rt); id(1, rs, rt, 1, 1, d, 1, 0); endtask
  task automatic lw(input int d, input int b); id(1, b, 0, 1, 0, d, 1, 1); endtask
  task automatic do_reset;
    rst = 1; nop; ex_br_taken = 0; mem_busy = 0;
    step; step;
    rst = 0;
  endtask
  initial begin
    nop;
    step;
    armed = 1;
    settle;
    chk("rst_pc_en", pc_en[0], 0);
    chk("rst_ifid_en", ifid_en[0], 0);
    chk("rst_ifid_flush", ifid_flush[0], 1);
    chk("rst_idex_flush", idex_flush[0], 1);
    step; rst = 0; settle;
    chk("post_rst_pc_en", pc_en[0], 1);
    chk("post_rst_flush", {ifid_flush[0], idex_flush[0]}, 0);
    chk("post_rst_stall_cnt", sc0, 0);
    alu(3, 1, 2); step; alu(6, 3, 7); settle;
    chk("fwd1_no_stall", pc_en[0], 1);
    step; nop; settle;
    chk("fwd1_exmem", fwd_a[0], 1);
    chk("fwd1_b_none", fwd_b[0], 0);
    alu(3, 1, 2); step; nop; step; alu(6, 3, 7); step; nop; settle;
    chk("fwd2_memwb", fwd_a[0], 2);
    do_reset;
    lw(4, 1); step; alu(5, 4, 2); settle;
    chk("lu_pc_en", pc_en[0], 0);
    chk("lu_ifid_en", ifid_en[0], 0);
    chk("lu_idex_flush", idex_flush[0], 1);
    step; settle;
    chk("lu_release", pc_en[0], 1);
    step; nop; settle;
    chk("lu_fwd", fwd_a[0], 2);
    chk("lu_stall_cnt", sc0, 1);
    do_reset;
    alu(5, 1, 2); step; alu(6, 5, 5); settle;
    chk("nofwd_stall1", pc_en[1], 0);
    step; settle;
    chk("nofwd_stall2", pc_en[1], 0);
    step; settle;
    chk("nofwd_go", pc_en[1], 1);
    chk("nofwd_stall_cnt", sc1, 2);
    step; nop; settle;
    chk("nofwd_fwd_a", fwd_a[1], 0);
    do_reset;
    lw(4, 1); step; alu(5, 4, 2); ex_br_taken = 1; settle;
    chk("br_ifid_flush", ifid_flush[0], 1);
    chk("br_idex_flush", idex_flush[0], 1);
    chk("br_pc_en", pc_en[0], 1);
    step; ex_br_taken = 0; nop; settle;
    chk("br_flush_cnt", fc0, 1);
    chk("br_stall_cnt", sc0, 0);
    do_reset;
    lw(4, 1); step; alu(5, 4, 2); mem_busy = 1; settle;
    chk("busy_pc_en", pc_en[0], 0);
    chk("busy_ifid_en", ifid_en[0], 0);
    chk("busy_idex_flush", idex_flush[0], 0);
    step; step; settle;
    chk("busy_hold_pc", pc_en[0], 0);
    chk("busy_hold_cnt", sc0, 0);
    step; mem_busy = 0; settle;
    chk("busy_resume_hz", idex_flush[0], 1);
    step; settle;
    chk("busy_resume_go", pc_en[0], 1);
    chk("busy_resume_cnt", sc0, 1);
    do_reset;
    lw(4, 1); step; alu(5, 4, 2); settle;
    chk("midrst_stall", pc_en[0], 0);
    rst = 1; step; rst = 0; nop; settle;
    chk("midrst_go", pc_en[0], 1);
    chk("midrst_idex", idex_flush[0], 0);
    chk("midrst_cnt", sc0, 0);
    do_reset;
    alu(0, 1, 2); step; alu(6, 0, 0); settle;
    chk("r0_no_stall_nofwd", pc_en[2], 1);
    chk("r0_no_stall_fwd", pc_en[0], 1);
    step; nop; settle;
    chk("r0_fwd", {fwd_a[0], fwd_b[0]}, 0);
    for (int r = 0; r < 2; r++) begin
      alu(5, 1, 2); step; alu(6, 5, 5);
      for (int i = 0; i < 4; i++) step;
      nop;
    end
    settle;
    chk("sat_stall_cnt", sc2, 3);
    step; step;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
